// File: rtl/mul_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   W_DEF   : default operand width
package mul_shift_add_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_adder_wc.sv
// W-bit ripple-carry adder with carry-out, built from full_adder cells.
// Ports:
//   x, y  [W-1:0] in  : addends
//   cin           in  : carry-in
//   s     [W-1:0] out : sum
//   cout          out : carry-out of the top bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_wc #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[W];
endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Ports:
//   clk            in  : clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   start          in  : request a multiply (ignored while busy)
//   a     [W-1:0]  in  : multiplicand, latched on accept
//   b     [W-1:0]  in  : multiplier, latched on accept
//   busy           out : iterations in progress
//   done           out : one-cycle pulse, p valid from here on
//   p     [2W-1:0] out : product, held until the next result
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// RUN    | one multiplier bit consumed per edge, W edges total
// DONE   | result just written to p; start here re-launches with no bubble
module mul_shift_add
  import mul_shift_add_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [W-1:0]     mcand_q,  mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d;
  logic [2*W-1:0]   p_q,      p_d;

  logic [W-1:0]     add_s;
  logic             add_c;
  logic [W:0]       step_sum;
  logic [2*W-1:0]   shifted;

  adder_wc #(.W(W)) u_adder (
    .x    (acc_hi_q),
    .y    (mcand_q),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  // Carry is kept as the (2W+1)-th bit so the right shift pulls it into acc_hi.
  assign step_sum = mplier_q[0] ? {add_c, add_s} : {1'b0, acc_hi_q};
  assign shifted  = {step_sum, mplier_q[W-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_hi_d = acc_hi_q;
    p_d      = p_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_hi_d = shifted[2*W-1:W];
        mplier_d = shifted[W-1:0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          p_d     = shifted;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_mul_shift_add.sv
module tb_mul_shift_add;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int errors;
  int checks;

  mul_shift_add #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_p(input string name, input logic [7:0] exp);
    checks++;
    if (p !== exp) begin
      errors++;
      $display("FAIL %s: p got %h expected %h", name, p, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    #12;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_p("reset_p", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bit("idle_busy", busy, 1'b0);
      chk_bit("idle_done", done, 1'b0);
      chk_p("idle_p", 8'h00);
    end
  endtask

  // Full operation with a start pulse; inputs scrambled after accept.
  task automatic run_op(input string name, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [7:0] exp, input logic [7:0] prev_p);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ia;
    b = ib ^ 4'h5;
    for (int i = 0; i < 4; i++) begin
      chk_bit({name, "_busy"}, busy, 1'b1);
      chk_bit({name, "_nodone"}, done, 1'b0);
      chk_p({name, "_p_held_run"}, prev_p);
      tick();
    end
    chk_bit({name, "_done"}, done, 1'b1);
    chk_bit({name, "_busy_in_done"}, busy, 1'b0);
    chk_p({name, "_p"}, exp);
    tick();
    chk_bit({name, "_done_pulse"}, done, 1'b0);
    chk_p({name, "_p_hold"}, exp);
    tick();
    chk_p({name, "_p_hold2"}, exp);
  endtask

  task automatic test_basic();
    run_op("mul_5x10", 4'h5, 4'ha, 8'h32, 8'h00);
    run_op("mul_15x15", 4'hf, 4'hf, 8'he1, 8'h32);
    run_op("mul_0x9", 4'h0, 4'h9, 8'h00, 8'he1);
  endtask

  task automatic test_back_to_back();
    a = 4'h7;
    b = 4'ha;
    start = 1'b1;
    tick();
    a = 4'h1;
    b = 4'hf;
    for (int i = 0; i < 4; i++) begin
      chk_bit("b2b_busy1", busy, 1'b1);
      tick();
    end
    chk_bit("b2b_done1", done, 1'b1);
    chk_p("b2b_p1", 8'h46);
    tick();
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("b2b_busy2", busy, 1'b1);
      chk_bit("b2b_nodone2", done, 1'b0);
      tick();
    end
    chk_bit("b2b_done2", done, 1'b1);
    chk_p("b2b_p2", 8'h0f);
    tick();
    chk_bit("b2b_idle", busy | done, 1'b0);
  endtask

  task automatic test_start_ignored();
    int n_done;
    n_done = 0;
    a = 4'h2;
    b = 4'h6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'h3;
    b = 4'h3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        n_done++;
        chk_p("ign_p", 8'h0c);
      end
      tick();
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ign_done_count: got %0d expected 1", n_done);
    end
    chk_p("ign_p_final", 8'h0c);
    chk_bit("ign_idle_busy", busy, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    a = 4'hb;
    b = 4'hd;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_bit("rst_mid_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("rst_mid_busy", busy, 1'b0);
    chk_bit("rst_mid_done", done, 1'b0);
    chk_p("rst_mid_p", 8'h00);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_bit("rst_mid_no_done", done, 1'b0);
      chk_bit("rst_mid_no_busy", busy, 1'b0);
    end
    run_op("mul_9x9", 4'h9, 4'h9, 8'h51, 8'h00);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
